fft4_ctrl: RTL and testbench
============================

FFT4_CTRL -- requirements
Module: fft4_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: input sample width and fft4 input width.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum cycles spent in WAIT before abort (range 1..255).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_valid, input, 1: input sample valid.
REQ-006 SHALL have port s_ready, output, 1: controller accepts an input sample.
REQ-007 SHALL have ports s_real and s_imag, input, DATA_WIDTH each, signed: input sample.
REQ-008 SHALL have port fft_en, output, 1: start strobe to fft4 en.
REQ-009 SHALL have ports fft_in_real and fft_in_imag, output, 4*DATA_WIDTH each: packed operands; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH] drives fft4 ink.
REQ-010 SHALL have port fft_valid, input, 1: fft4 yout_valid.
REQ-011 SHALL have ports fft_out_real and fft_out_imag, input, 4*(DATA_WIDTH+2) each: packed fft4 outputs, lane k = outk.
REQ-012 SHALL have port m_valid, output, 1: output bin valid.
REQ-013 SHALL have port m_ready, input, 1: downstream accepts a bin.
REQ-014 SHALL have ports m_real and m_imag, output, DATA_WIDTH+2 each, signed: output bin.
REQ-015 SHALL have port m_last, output, 1: high with bin 3.
REQ-016 SHALL have port busy, output, 1: high in any state except COLLECT.
REQ-017 SHALL have port err_timeout, output, 1: one-cycle abort pulse.

Function
REQ-018 SHALL implement FSM states COLLECT, FIRE, WAIT, DRAIN; one frame in flight, no overlap.
REQ-019 COLLECT: s_ready=1; each cycle with s_valid&&s_ready SHALL store the sample in lane idx (idx 0..3, counting from 0) and increment idx.
REQ-020 Acceptance with idx==3 SHALL clear idx and move to FIRE next cycle.
REQ-021 FIRE: fft_en=1 for exactly one cycle, s_ready=0, then WAIT.
REQ-022 fft_in_real and fft_in_imag SHALL be registered and change only on COLLECT acceptances; stable from FIRE through DRAIN.
REQ-023 WAIT: fft_en=0; timeout counter SHALL clear on entry and increment each cycle.
REQ-024 WAIT with fft_valid=1 SHALL capture all four output lanes into an internal buffer and move to DRAIN; fft_valid outside WAIT SHALL be ignored.
REQ-025 WAIT with counter==TIMEOUT and fft_valid=0 SHALL pulse err_timeout for one cycle, discard the frame and return to COLLECT with idx=0.
REQ-026 If fft_valid=1 in the cycle the counter reaches TIMEOUT, capture SHALL win and no error pulse SHALL occur.
REQ-027 DRAIN: m_valid=1, m_real/m_imag = buffer lane oidx, m_last=(oidx==3); oidx starts at 0.
REQ-028 m_valid&&m_ready SHALL advance oidx; the handshake at oidx==3 SHALL return to COLLECT next cycle.
REQ-029 While m_valid=1 and m_ready=0, m_real, m_imag and m_last SHALL hold stable.
REQ-030 Latency: last input acceptance to fft_en = 1 cycle; fft_valid sampled to m_valid = 1 cycle.
REQ-031 No arithmetic in the controller; bins SHALL pass at full DATA_WIDTH+2 width, unmodified.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state COLLECT, idx=0, oidx=0, timeout counter=0, fft_en=0, m_valid=0, m_last=0, busy=0, err_timeout=0, fft_in_*=0, buffer=0.
REQ-033 s_ready SHALL be 0 while rst_n=0 and 1 from the first clock edge after release.
REQ-034 Reset mid-frame (any state) SHALL discard the frame; no partial output SHALL appear after release.

Verification
REQ-035 Impulse: inputs (1,0),(0,0),(0,0),(0,0) -> bins (1,0),(1,0),(1,0),(1,0), m_last on bin 3.
REQ-036 Ramp: inputs real 1,2,3,4, imag 0 -> bins (10,0),(-2,2),(-2,0),(-2,-2).
REQ-037 Backpressure: m_ready low 3 cycles on bin 1 -> bin 1 held stable, no bin lost or duplicated, s_ready=0 until the bin 3 handshake.
REQ-038 Timeout: fft_valid held 0 -> err_timeout single pulse TIMEOUT+1 cycles after fft_en, s_ready=1 next cycle, no m_valid.
REQ-039 Gapped input: s_valid toggling every other cycle -> exactly one fft_en after the 4th accept; fft_in lanes match input order.
REQ-040 Reset in DRAIN after bin 1 -> all outputs at reset values immediately; next full frame processes correctly from bin 0.

Source files
------------

// File: rtl/fft4_ctrl.sv
// Frame controller around a 4-point FFT core: gathers four samples, fires the
// core once, waits (bounded) for its result and streams the four bins out.
module fft4_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic signed [DATA_WIDTH-1:0]    s_real,
  input  logic signed [DATA_WIDTH-1:0]    s_imag,
  output logic                            fft_en,
  output logic [4*DATA_WIDTH-1:0]         fft_in_real,
  output logic [4*DATA_WIDTH-1:0]         fft_in_imag,
  input  logic                            fft_valid,
  input  logic [4*(DATA_WIDTH+2)-1:0]     fft_out_real,
  input  logic [4*(DATA_WIDTH+2)-1:0]     fft_out_imag,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic signed [DATA_WIDTH+1:0]    m_real,
  output logic signed [DATA_WIDTH+1:0]    m_imag,
  output logic                            m_last,
  output logic                            busy,
  output logic                            err_timeout
);
  localparam int OW = DATA_WIDTH + 2;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {COLLECT, FIRE, WAIT, DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [1:0]                  idx, oidx;
  logic [7:0]                  tcnt;
  logic                        live;
  logic [3:0][DATA_WIDTH-1:0]  in_re, in_im;
  logic [3:0][OW-1:0]          buf_re, buf_im;
  logic                        s_acc, m_acc;

  assign s_acc = s_valid && s_ready;
  assign m_acc = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (s_acc && idx == 2'd3) state_nxt = FIRE;
      FIRE:    state_nxt = WAIT;
      // a result arriving on the last allowed cycle still wins over the abort
      WAIT:    if (fft_valid) state_nxt = DRAIN;
               else if (tcnt == TO_CNT) state_nxt = COLLECT;
      DRAIN:   if (m_acc && oidx == 2'd3) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    s_ready     = 1'b0;
    fft_en      = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    busy        = 1'b1;
    err_timeout = 1'b0;
    case (state)
      COLLECT: begin s_ready = live; busy = 1'b0; end
      FIRE:    fft_en = 1'b1;
      WAIT:    err_timeout = !fft_valid && (tcnt == TO_CNT);
      DRAIN:   begin m_valid = 1'b1; m_last = (oidx == 2'd3); end
      default: ;
    endcase
  end

  // live keeps s_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= 1'b0;
      idx    <= '0;
      oidx   <= '0;
      tcnt   <= '0;
      in_re  <= '0;
      in_im  <= '0;
      buf_re <= '0;
      buf_im <= '0;
    end else begin
      live <= 1'b1;
      if (s_acc) begin
        in_re[idx] <= s_real;
        in_im[idx] <= s_imag;
        idx        <= idx + 2'd1;
      end
      if (state == FIRE)      tcnt <= '0;
      else if (state == WAIT) tcnt <= tcnt + 8'd1;
      if (state == WAIT && fft_valid) begin
        buf_re <= fft_out_real;
        buf_im <= fft_out_imag;
      end
      if (m_acc) oidx <= oidx + 2'd1;
    end
  end

  assign fft_in_real = in_re;
  assign fft_in_imag = in_im;
  assign m_real      = buf_re[oidx];
  assign m_imag      = buf_im[oidx];
endmodule

// File: tb/tb_fft4_ctrl.sv
// Bench for fft4_ctrl: table of frames plus randomized frames, with a stand-in
// FFT core and a direct-DFT reference for the expected bins.
module tb_fft4_ctrl;
  localparam int DW = 8;
  localparam int OW = DW + 2;
  localparam int TO = 6;

  typedef struct packed { logic signed [DW-1:0] re; logic signed [DW-1:0] im; } smp_t;
  typedef struct packed { logic signed [OW-1:0] re; logic signed [OW-1:0] im; } bin_t;
  typedef smp_t [3:0] frame_t;
  typedef bin_t [3:0] bins_t;
  typedef struct packed { frame_t x; bins_t eb; int lat; bit gap; int bpm; bit exp_err; } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid, s_ready, fft_en, fft_valid, m_valid, m_ready, m_last, busy, err_timeout;
  logic signed [DW-1:0] s_real, s_imag;
  logic [4*DW-1:0] fft_in_real, fft_in_imag;
  logic [4*OW-1:0] fft_out_real, fft_out_imag;
  logic signed [OW-1:0] m_real, m_imag;

  fft4_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag), .fft_en(fft_en),
    .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
    .fft_valid(fft_valid), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_last(m_last), .busy(busy), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int fft_lat = 1, cd = 0, res_cyc = -100, bp_mode = 0, stall_left = 0;
  bit spur_en = 1'b0;
  int acc_n = 0, acc_cyc = 0, fire_n = 0, fire_cyc = 0, err_n = 0, err_cyc = 0, mv_n = 0;
  smp_t acc[$];
  bin_t got[$];
  logic prev_mv = 1'b0, prev_mr = 1'b0, prev_last = 1'b0, prev_err = 1'b0;
  logic signed [OW-1:0] prev_re, prev_im;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic smp_t mk(input int r, input int i);
    mk.re = r[DW-1:0]; mk.im = i[DW-1:0];
  endfunction

  function automatic frame_t frm(input int r0, i0, r1, i1, r2, i2, r3, i3);
    frm[0] = mk(r0, i0); frm[1] = mk(r1, i1); frm[2] = mk(r2, i2); frm[3] = mk(r3, i3);
  endfunction

  function automatic bins_t bns(input int r0, i0, r1, i1, r2, i2, r3, i3);
    bns[0].re = r0[OW-1:0]; bns[0].im = i0[OW-1:0];
    bns[1].re = r1[OW-1:0]; bns[1].im = i1[OW-1:0];
    bns[2].re = r2[OW-1:0]; bns[2].im = i2[OW-1:0];
    bns[3].re = r3[OW-1:0]; bns[3].im = i3[OW-1:0];
  endfunction

  // Reference: X[k] = sum_n x[n] * exp(-j*2*pi*n*k/4), twiddles from a table.
  function automatic bins_t dft(input frame_t x);
    int twr[4] = '{1, 0, -1, 0};
    int twi[4] = '{0, -1, 0, 1};
    for (int k = 0; k < 4; k++) begin
      int sr = 0, si = 0;
      for (int n = 0; n < 4; n++) begin
        int m = (n * k) % 4;
        int xr = $signed(x[n].re);
        int xi = $signed(x[n].im);
        sr += xr * twr[m] - xi * twi[m];
        si += xr * twi[m] + xi * twr[m];
      end
      dft[k].re = sr[OW-1:0]; dft[k].im = si[OW-1:0];
    end
  endfunction

  function automatic vec_t mkv(input frame_t x, input bins_t eb, input int lat,
                               input bit gap, input int bpm, input bit ee);
    mkv.x = x; mkv.eb = eb; mkv.lat = lat; mkv.gap = gap; mkv.bpm = bpm; mkv.exp_err = ee;
  endfunction

  // Stand-in FFT core: radix-2 butterflies, result fft_lat cycles after fft_en.
  initial begin
    int xr[4], xi[4], yr[4], yi[4];
    int a1r, a1i, b1r, b1i;
    fft_valid = 1'b0; fft_out_real = '0; fft_out_imag = '0;
    forever begin
      @(posedge clk); #1;
      fft_valid = 1'b0;
      if (!rst_n) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            for (int n = 0; n < 4; n++) begin
              xr[n] = $signed(fft_in_real[n*DW +: DW]);
              xi[n] = $signed(fft_in_imag[n*DW +: DW]);
            end
            a1r = xr[0] - xr[2]; a1i = xi[0] - xi[2];
            b1r = xr[1] - xr[3]; b1i = xi[1] - xi[3];
            yr[0] = xr[0] + xr[2] + xr[1] + xr[3]; yi[0] = xi[0] + xi[2] + xi[1] + xi[3];
            yr[2] = xr[0] + xr[2] - xr[1] - xr[3]; yi[2] = xi[0] + xi[2] - xi[1] - xi[3];
            yr[1] = a1r + b1i; yi[1] = a1i - b1r;
            yr[3] = a1r - b1i; yi[3] = a1i + b1r;
            for (int k = 0; k < 4; k++) begin
              fft_out_real[k*OW +: OW] = OW'(yr[k]);
              fft_out_imag[k*OW +: OW] = OW'(yi[k]);
            end
            fft_valid = 1'b1; res_cyc = cyc;
          end
        end
        // junk results while idle or draining must be ignored
        if (!fft_valid && spur_en && (!busy || m_valid) && $urandom_range(0, 2) == 0) begin
          fft_valid = 1'b1;
          fft_out_real = 40'({$urandom, $urandom});
          fft_out_imag = 40'({$urandom, $urandom});
        end
        if (fft_en && fft_lat > 0) cd = fft_lat;
      end
    end
  end

  // Sink: backpressure policy on m_ready.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_mode == 1) m_ready = 1'($urandom_range(0, 1));
      else if (bp_mode == 2 && m_valid && got.size() == 1 && stall_left > 0) begin
        m_ready = 1'b0; stall_left--;
      end else m_ready = 1'b1;
    end
  end

  // Monitor: samples just before each rising edge.
  initial forever begin
    @(negedge clk); #4;
    if (!rst_n) begin
      prev_mv = 1'b0; prev_err = 1'b0; acc_n = 0; acc.delete();
    end else begin
      if (prev_err) chk("ready_after_timeout", s_ready, 1);
      if (s_valid && s_ready) begin
        acc.push_back(mk(s_real, s_imag)); acc_n++; acc_cyc = cyc;
      end
      if (fft_en) begin
        fire_n++; fire_cyc = cyc;
        chk("fire_latency", cyc, acc_cyc + 1);
        chk("accepts_per_fire", acc_n, 4);
        if (acc.size() >= 4)
          for (int k = 0; k < 4; k++) begin
            chk("fft_in_real_lane", $signed(fft_in_real[k*DW +: DW]), acc[acc.size()-4+k].re);
            chk("fft_in_imag_lane", $signed(fft_in_imag[k*DW +: DW]), acc[acc.size()-4+k].im);
          end
        acc_n = 0;
      end
      if (err_timeout) begin err_n++; err_cyc = cyc; end
      if (prev_mv && !prev_mr) begin
        chk("hold_valid", m_valid, 1);
        if (m_valid) begin
          chk("hold_real", m_real, prev_re);
          chk("hold_imag", m_imag, prev_im);
          chk("hold_last", m_last, prev_last);
        end
      end
      if (m_valid) begin
        mv_n++;
        chk("s_ready_in_drain", s_ready, 0);
        if (!prev_mv) chk("result_latency", cyc, res_cyc + 1);
        if (m_ready) begin
          chk("m_last", m_last, (got.size() % 4) == 3);
          got.push_back('{re: m_real, im: m_imag});
        end
      end
      prev_mv = m_valid; prev_mr = m_ready; prev_last = m_last;
      prev_re = m_real; prev_im = m_imag; prev_err = err_timeout;
    end
  end

  task automatic send(input frame_t x, input bit gap);
    int n = 0, g = 0;
    while (n < 4 && g < 200) begin
      @(negedge clk);
      if (gap && g % 2 == 1) s_valid = 1'b0;
      else begin
        s_valid = 1'b1; s_real = x[n].re; s_imag = x[n].im;
        if (s_ready) n++;
      end
      g++;
    end
    chk("all_samples_accepted", n, 4);
    @(negedge clk); s_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int e0 = err_n, f0 = fire_n, m0 = mv_n, guard = 0;
    got.delete(); fft_lat = v.lat; bp_mode = v.bpm; stall_left = 3;
    send(v.x, v.gap);
    if (v.exp_err) begin
      while (err_n == e0 && guard < 100) begin @(negedge clk); guard++; end
      repeat (TO + 4) @(negedge clk);
      chk("timeout_pulses", err_n - e0, 1);
      chk("timeout_cycle", err_cyc, fire_cyc + TO + 1);
      chk("no_bins_on_abort", mv_n - m0, 0);
    end else begin
      while (got.size() < 4 && guard < 300) begin @(negedge clk); guard++; end
      repeat (3) @(negedge clk);
      chk("bin_count", got.size(), 4);
      chk("no_timeout", err_n - e0, 0);
      for (int k = 0; k < 4 && k < got.size(); k++) begin
        chk("bin_real", got[k].re, v.eb[k].re);
        chk("bin_imag", got[k].im, v.eb[k].im);
      end
    end
    chk("one_fire", fire_n - f0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int m0, guard;
    s_valid = 1'b0; s_real = '0; s_imag = '0;

    tbl[0] = mkv(frm(1,0, 0,0, 0,0, 0,0), bns(1,0, 1,0, 1,0, 1,0), 2, 1'b0, 0, 1'b0);
    tbl[1] = mkv(frm(1,0, 2,0, 3,0, 4,0), bns(10,0, -2,2, -2,0, -2,-2), 1, 1'b0, 0, 1'b0);
    tbl[2] = mkv(frm(1,0, 2,0, 3,0, 4,0), bns(10,0, -2,2, -2,0, -2,-2), 3, 1'b1, 2, 1'b0);
    tbl[3] = mkv(frm(0,1, 0,0, 0,0, 0,0), bns(0,1, 0,1, 0,1, 0,1), TO + 1, 1'b0, 1, 1'b0);
    tbl[4] = mkv(frm(1,0, 2,0, 3,0, 4,0), bns(0,0, 0,0, 0,0, 0,0), 0, 1'b0, 0, 1'b1);
    tbl[5] = mkv(frm(1,0, 0,0, 0,0, 0,0), bns(0,0, 0,0, 0,0, 0,0), TO + 2, 1'b0, 0, 1'b1);
    tbl[6] = mkv(frm(127,-128, -128,127, 127,127, -128,-128),
                 bns(-2,-2, 255,-255, 510,0, -255,-255), 4, 1'b0, 1, 1'b0);

    // reset state
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fft_en", fft_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_fft_in_real", fft_in_real, 0);
    chk("rst_fft_in_imag", fft_in_imag, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    chk("s_ready_before_first_edge", s_ready, 0);
    @(negedge clk); #1;
    chk("s_ready_after_first_edge", s_ready, 1);

    for (int t = 0; t < 7; t++) run_frame(tbl[t]);

    // reset while draining, after bin 1 has been taken
    got.delete(); fft_lat = 2; bp_mode = 0; guard = 0;
    send(tbl[1].x, 1'b0);
    while (got.size() < 2 && guard < 100) begin @(negedge clk); guard++; end
    chk("bins_before_reset", got.size(), 2);
    #2 rst_n = 1'b0; #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_last", m_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_fft_en", fft_en, 0);
    chk("mid_rst_err", err_timeout, 0);
    chk("mid_rst_fft_in_real", fft_in_real, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; m0 = mv_n;
    repeat (6) @(negedge clk);
    chk("no_partial_output", mv_n - m0, 0);
    chk("s_ready_after_mid_rst", s_ready, 1);
    run_frame(tbl[0]);

    // randomized frames with junk fft_valid traffic and random backpressure
    spur_en = 1'b1;
    for (int r = 0; r < 16; r++) begin
      frame_t x;
      int l;
      bit ee;
      for (int n = 0; n < 4; n++) begin
        x[n].re = 8'($urandom); x[n].im = 8'($urandom);
      end
      l = $urandom_range(1, TO + 1); ee = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        l = ($urandom_range(0, 1) == 1) ? 0 : TO + 2; ee = 1'b1;
      end
      run_frame(mkv(x, dft(x), l, 1'($urandom_range(0, 1)), 1, ee));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
